// File: rtl/sincos_pipe.sv
// sincos_pipe: 4-stage pipelined fixed-point sine/cosine generator.
// Parabolic approximation y = x*(B + C*|x|) with precision correction
// out = y + Pc*(y*|y| - y), computed in two parallel lanes (sin, cos).
// Angle is PDQP radians in [-pi, pi]; outputs are 3QP.
// Valid/ready stream with backpressure, pass-through tag, range-error flag.
// Optional macro SINCOS_SAT_EN: clamp both outputs to [-1.0, +1.0].
module sincos_pipe #(
  parameter int PD    = 4,
  parameter int P     = 22,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PD+P-1:0]    i_angle,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic               i_valid,
  output logic               i_ready,
  output logic [P+2:0]       o_sin,
  output logic [P+2:0]       o_cos,
  output logic [TAG_W-1:0]   o_tag,
  output logic               o_range_err,
  output logic               o_valid,
  input  logic               o_ready
);
  localparam int W   = PD + P;
  localparam int W2  = 2 * W;
  localparam int OW  = P + 3;
  localparam int SHL = (P >= 22) ? (P - 22) : 0;
  localparam int SHR = (P < 22) ? (22 - P) : 0;

  // Rescale a 4Q22 master constant to PDQP (MSB-aligned slice or LSB zero-extend)
  function automatic logic signed [W-1:0] q_const(input logic signed [25:0] m);
    return W'(($signed({{W{m[25]}}, m}) <<< SHL) >>> SHR);
  endfunction

  // Full-width signed product, truncated back to PDQP (no rounding)
  function automatic logic signed [W-1:0] mulq(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    logic signed [W2-1:0] ae;
    logic signed [W2-1:0] be;
    ae = {{W{a[W-1]}}, a};
    be = {{W{b[W-1]}}, b};
    return W'((ae * be) >>> P);
  endfunction

  localparam logic signed [W-1:0] K_ZERO = '0;
  localparam logic signed [W-1:0] K_PI   = q_const(26'sd13176794);
  localparam logic signed [W-1:0] K_NPI  = -K_PI;
  localparam logic signed [W-1:0] K_HPI  = q_const(26'sd6588397);
  localparam logic signed [W-1:0] K_2PI  = q_const(26'sd26353589);
  localparam logic signed [W-1:0] K_B    = q_const(26'sd5340354);
  localparam logic signed [W-1:0] K_C    = q_const(-26'sd1699887);
  localparam logic signed [W-1:0] K_PC   = q_const(26'sd943718);
  localparam logic signed [W-1:0] K_ONE  = q_const(26'sd4194304);
  localparam logic signed [W-1:0] K_NONE = -K_ONE;

  logic                 en;
  logic signed [W-1:0]  ang;
  logic                 rerr;
  logic [3:0]           vld_reg;
  logic [3:0]           err_reg;
  logic [TAG_W-1:0]     tag_reg [4];

  assign ang     = $signed(i_angle);
  assign rerr    = (ang > K_PI) || (ang < K_NPI);
  // All stages move together unless the output is held by the consumer
  assign en      = ~vld_reg[3] | o_ready;
  assign i_ready = en;

  // Sideband pipeline: valid, range flag and tag travel with the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
      err_reg <= '0;
      for (int k = 0; k < 4; k++) tag_reg[k] <= '0;
    end else if (en) begin
      vld_reg    <= {vld_reg[2:0], i_valid};
      err_reg    <= {err_reg[2:0], rerr & i_valid};
      tag_reg[0] <= i_tag;
      for (int k = 1; k < 4; k++) tag_reg[k] <= tag_reg[k-1];
    end
  end

  assign o_valid     = vld_reg[3];
  assign o_range_err = err_reg[3];
  assign o_tag       = tag_reg[3];

  // Lane 0 computes sin(angle), lane 1 computes sin(angle + pi/2) = cos(angle)
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam logic signed [W-1:0] OFS = (gi == 0) ? K_ZERO : K_HPI;

    logic signed [W-1:0]  c;
    logic signed [W-1:0]  x;
    logic signed [W-1:0]  ax;
    logic signed [W-1:0]  m1;
    logic signed [W-1:0]  y;
    logic signed [W-1:0]  ay;
    logic signed [W-1:0]  m2;
    logic signed [W-1:0]  sum;
    logic signed [OW-1:0] res;

    logic signed [W-1:0]  s1_x_reg;
    logic signed [W-1:0]  s1_ax_reg;
    logic signed [W-1:0]  s2_y_reg;
    logic signed [W-1:0]  s3_y_reg;
    logic signed [W-1:0]  s3_m2_reg;
    logic signed [OW-1:0] out_reg;

    // Stage 1 logic: phase offset, wrap into [-pi, pi], magnitude
    always_comb begin
      c  = ang + OFS;
      x  = (c > K_PI) ? (c - K_2PI) : c;
      ax = x[W-1] ? -x : x;
    end

    // Stage 2 and 3 logic: parabola, then the correction term y*(|y|-1)
    always_comb begin
      m1 = mulq(K_C, s1_ax_reg);
      y  = mulq(s1_x_reg, m1 + K_B);
      ay = s2_y_reg[W-1] ? -s2_y_reg : s2_y_reg;
      m2 = mulq(s2_y_reg, ay - K_ONE);
    end

    // Stage 4 logic: apply weighted correction and narrow to 3QP
    always_comb begin
      sum = s3_y_reg + mulq(K_PC, s3_m2_reg);
`ifdef SINCOS_SAT_EN
      if (sum > K_ONE)       res = OW'(K_ONE);
      else if (sum < K_NONE) res = OW'(K_NONE);
      else                   res = OW'(sum);
`else
      res = OW'(sum);
`endif
    end

    // Lane data registers, advancing in lock-step with the sideband pipeline
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_x_reg  <= '0;
        s1_ax_reg <= '0;
        s2_y_reg  <= '0;
        s3_y_reg  <= '0;
        s3_m2_reg <= '0;
        out_reg   <= '0;
      end else if (en) begin
        s1_x_reg  <= x;
        s1_ax_reg <= ax;
        s2_y_reg  <= y;
        s3_y_reg  <= s2_y_reg;
        s3_m2_reg <= m2;
        out_reg   <= res;
      end
    end
  end

  assign o_sin = g_lane[0].out_reg;
  assign o_cos = g_lane[1].out_reg;

endmodule

// File: tb/tb_sincos_pipe.sv
// tb_sincos_pipe: directed and backpressure checks for sincos_pipe
// (PD=4, P=22, TAG_W=4). Results are compared against ideal sin/cos with
// a tolerance of 0.0015 + 8 LSB.
module tb_sincos_pipe;
  localparam longint ONE   = 4194304;
  localparam longint PI_Q  = 13176794;
  localparam longint HPI_Q = 6588397;
  localparam longint TOL   = 6300;   // 0.0015*2^22 = 6291.5, plus 8 LSB

  typedef struct {
    longint ang;
    int     tag;
    bit     err;
    longint es;
    longint ec;
    int     acc_cyc;
    bit     chk_val;
    bit     chk_lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [25:0] i_angle;
  logic [3:0]  i_tag;
  logic        i_valid;
  logic        i_ready;
  logic [24:0] o_sin;
  logic [24:0] o_cos;
  logic [3:0]  o_tag;
  logic        o_range_err;
  logic        o_valid;
  logic        o_ready;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cur_run = 0;
  int   max_run = 0;
  exp_t src[$];
  exp_t expq[$];

  sincos_pipe #(.PD(4), .P(22), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_angle(i_angle), .i_tag(i_tag),
    .i_valid(i_valid), .i_ready(i_ready), .o_sin(o_sin), .o_cos(o_cos),
    .o_tag(o_tag), .o_range_err(o_range_err), .o_valid(o_valid),
    .o_ready(o_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint got,
                           input longint expv, input longint tol);
    checks++;
    if (got - expv > tol || expv - got > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, expv, tol);
    end
  endtask

  task automatic add(input longint ang, input int tag, input longint es,
                     input longint ec, input bit chk_val, input bit chk_lat);
    exp_t e;
    e.ang = ang; e.tag = tag; e.es = es; e.ec = ec;
    e.err = (ang > PI_Q) || (ang < -PI_Q);
    e.acc_cyc = 0; e.chk_val = chk_val; e.chk_lat = chk_lat;
    src.push_back(e);
  endtask

  task automatic add_model(input longint ang, input int tag);
    real a;
    a = $itor(ang) / 4194304.0;
    add(ang, tag, longint'($rtoi($floor($sin(a) * 4194304.0 + 0.5))),
        longint'($rtoi($floor($cos(a) * 4194304.0 + 0.5))), 1'b1, 1'b0);
  endtask

  // Drive the source queue and score outputs until both queues drain
  task automatic run(input int vpct, input int rpct, input int max_cyc);
    exp_t e;
    int   n;
    bit   acc;
    int   c0;
    n = 0; cur_run = 0; max_run = 0;
    while ((src.size() > 0 || expq.size() > 0) && n < max_cyc) begin
      @(negedge clk);
      if (src.size() > 0 && $urandom_range(99) < vpct) begin
        i_valid = 1'b1;
        i_angle = 26'(src[0].ang);
        i_tag   = 4'(src[0].tag);
      end else begin
        i_valid = 1'b0;
      end
      o_ready = ($urandom_range(99) < rpct);
      #1;
      c0 = cyc;
      check_val("i_ready", longint'(i_ready), longint'(!(o_valid && !o_ready)), 0);
      if (o_valid) begin
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else begin
        cur_run = 0;
      end
      if (o_valid && o_ready) begin
        if (expq.size() == 0) begin
          check_val("spurious_out", 1, 0, 0);
        end else begin
          e = expq.pop_front();
          $display("out tag=%0d sin=%0d cos=%0d err=%0b", o_tag,
                   longint'($signed(o_sin)), longint'($signed(o_cos)), o_range_err);
          check_val("tag", longint'(o_tag), longint'(e.tag), 0);
          check_val("range_err", longint'(o_range_err), longint'(e.err), 0);
          if (e.chk_val) begin
            check_val("sin", longint'($signed(o_sin)), e.es, TOL);
            check_val("cos", longint'($signed(o_cos)), e.ec, TOL);
          end
          if (e.chk_lat) check_val("latency", longint'(c0 - e.acc_cyc), 4, 0);
`ifdef SINCOS_SAT_EN
          check_val("sat_sin", longint'($signed(o_sin)), 0, ONE);
          check_val("sat_cos", longint'($signed(o_cos)), 0, ONE);
`endif
        end
      end
      acc = i_valid && i_ready;
      @(posedge clk);
      if (acc) begin
        e = src.pop_front();
        e.acc_cyc = c0;
        expq.push_back(e);
      end
      n++;
    end
    check_val("drain", longint'(src.size() + expq.size()), 0, 0);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // Idle cycles with the output ready: nothing may come out
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_valid = 1'b0;
      o_ready = 1'b1;
      #1;
      check_val("idle_o_valid", longint'(o_valid), 0, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b1; i_angle = 26'd1000; i_tag = 4'd9; o_ready = 1'b1;

    // Reset held with a valid input present
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_o_valid", longint'(o_valid), 0, 0);
    check_val("rst_o_sin", longint'(o_sin), 0, 0);
    check_val("rst_o_cos", longint'(o_cos), 0, 0);
    check_val("rst_o_tag", longint'(o_tag), 0, 0);
    check_val("rst_o_range_err", longint'(o_range_err), 0, 0);
    @(negedge clk);
    i_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_val("rst_i_ready", longint'(i_ready), 1, 0);
    idle(6);

    // Single sample at angle 0: sin=0, cos=1.0, latency 4
    add(0, 3, 0, ONE, 1'b1, 1'b1);
    run(100, 100, 50);

    // Back-to-back sweep of the quadrant points, both +pi and -pi boundaries
    add( HPI_Q, 1,    ONE,    0, 1'b1, 1'b0);
    add( PI_Q,  2,      0, -ONE, 1'b1, 1'b0);
    add(-HPI_Q, 3,   -ONE,    0, 1'b1, 1'b0);
    add(-PI_Q,  4,      0, -ONE, 1'b1, 1'b0);
    run(100, 100, 50);
    check_val("sweep_valid_run", longint'(max_run), 4, 0);

    // Out-of-range angle between two legal neighbours (0.5 rad values hand-derived)
    add( 2097152,        5,  2010856, 3680848, 1'b1, 1'b0);
    add(PI_Q + 419430,   6,        0,       0, 1'b0, 1'b0);
    add(-2097152,        7, -2010856, 3680848, 1'b1, 1'b0);
    run(100, 100, 50);

    // Random angles under random input gaps and output backpressure
    for (int k = 0; k < 16; k++)
      add_model(longint'($urandom_range(2 * PI_Q)) - PI_Q, k);
    run(70, 50, 2000);

    // Reset while three samples are in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_angle = 26'(k * 1000000);
      i_tag   = 4'(k + 8);
      o_ready = 1'b1;
    end
    @(negedge clk);
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("midrst_o_valid", longint'(o_valid), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);

`ifdef SINCOS_SAT_EN
    // Dense sweep across [-pi, pi] with saturation active
    for (int k = 0; k < 4096; k++)
      add_model(-PI_Q + (2 * PI_Q * longint'(k)) / 4095, k % 16);
    run(100, 100, 5000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
